// File: rtl/parity_stream_unit.sv
// parity_stream_unit: one-stage valid/ready pipeline that forwards each beat with per-lane
// even/odd parity and mismatch flags. Optional saturating error counter: PARITY_ERR_COUNT_EN.
module parity_stream_unit #(
   parameter int DATA_WIDTH = 64,
   parameter int LANE_WIDTH = 8,
   parameter int CNT_WIDTH  = 16,
   localparam int LANES     = DATA_WIDTH / LANE_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  inValid,
   output logic                  inReady,
   input  logic [DATA_WIDTH-1:0] dataInput,
   input  logic [LANES-1:0]      parityInput,
   input  logic                  oddMode,
   output logic                  outValid,
   input  logic                  outReady,
   output logic [DATA_WIDTH-1:0] dataOutput,
   output logic [LANES-1:0]      parityOutput,
   output logic [LANES-1:0]      parityError,
   output logic                  anyError,
   input  logic                  clearCount,
   output logic [CNT_WIDTH-1:0]  errorCount
);

   generate
      if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_lane_width
         $error("parity_stream_unit: LANE_WIDTH must divide DATA_WIDTH");
      end
   endgenerate

   // Odd mode inverts the even-parity bit of every lane.
   function automatic logic [LANES-1:0] lane_parity(input logic [DATA_WIDTH-1:0] data,
                                                    input logic odd);
      logic [LANES-1:0] p;
      for (int i = 0; i < LANES; i++) begin
         p[i] = (^data[i*LANE_WIDTH +: LANE_WIDTH]) ^ odd;
      end
      return p;
   endfunction

   logic                  valid_r;
   logic [DATA_WIDTH-1:0] data_r;
   logic [LANES-1:0]      par_r;
   logic [LANES-1:0]      err_r;
   logic                  any_r;
   logic [LANES-1:0]      par_s;
   logic [LANES-1:0]      err_s;
   logic                  any_s;
   logic                  ready_s;
   logic                  accept_s;

   assign ready_s  = ~valid_r | outReady;
   assign accept_s = inValid & ready_s;

   // Parity and mismatch for the beat currently on the input.
   always_comb begin
      par_s = lane_parity(dataInput, oddMode);
      err_s = par_s ^ parityInput;
      any_s = |err_s;
   end

   // Output stage: loads on acceptance, drains on transfer, holds while stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_r <= 1'b0;
         data_r  <= {DATA_WIDTH{1'b0}};
         par_r   <= {LANES{1'b0}};
         err_r   <= {LANES{1'b0}};
         any_r   <= 1'b0;
      end else if (accept_s) begin
         valid_r <= 1'b1;
         data_r  <= dataInput;
         par_r   <= par_s;
         err_r   <= err_s;
         any_r   <= any_s;
      end else if (outReady) begin
         valid_r <= 1'b0;
      end else begin
         valid_r <= valid_r;
      end
   end

`ifdef PARITY_ERR_COUNT_EN
   logic [CNT_WIDTH-1:0] cnt_r;

   // Counts accepted error beats; clear dominates and the count never wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (clearCount) begin
         cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (accept_s && any_s && (cnt_r != {CNT_WIDTH{1'b1}})) begin
         cnt_r <= cnt_r + CNT_WIDTH'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign errorCount = cnt_r;
`else
   logic unused_clear_s;
   assign unused_clear_s = clearCount;
   assign errorCount     = {CNT_WIDTH{1'b0}};
`endif

   assign inReady      = ready_s;
   assign outValid     = valid_r;
   assign dataOutput   = data_r;
   assign parityOutput = par_r;
   assign parityError  = err_r;
   assign anyError     = any_r;

endmodule
